// File: rtl/mdp_run_scheduler_if.sv
// Host request/response and engine handshake bundle for the MDP run scheduler.
// The slave side is the scheduler; the master side is the host plus the engine.
interface mdp_run_scheduler_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_world;
    logic [7:0]  req_depth;
    logic [7:0]  req_width;
    logic [7:0]  req_iter;

    logic [63:0] eng_world;
    logic [7:0]  eng_depth;
    logic [7:0]  eng_width;
    logic [7:0]  eng_iter;
    logic        eng_start;
    logic        eng_ack;
    logic        eng_done;
    logic [63:0] eng_policy;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_policy;
    logic [7:0]  rsp_tag;
    logic        rsp_err;
    logic        rsp_tmo;

    modport slave (
        input  req_valid, req_world, req_depth, req_width, req_iter,
        output req_ready,
        output eng_world, eng_depth, eng_width, eng_iter, eng_start, eng_ack,
        input  eng_done, eng_policy,
        output rsp_valid, rsp_policy, rsp_tag, rsp_err, rsp_tmo,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_world, req_depth, req_width, req_iter,
        input  req_ready,
        input  eng_world, eng_depth, eng_width, eng_iter, eng_start, eng_ack,
        output eng_done, eng_policy,
        input  rsp_valid, rsp_policy, rsp_tag, rsp_err, rsp_tmo,
        output rsp_ready
    );
endinterface

// File: rtl/mdp_run_scheduler.sv
// Job queue and sequencer for the MDP value-iteration engine: buffers host jobs,
// runs them one at a time over a start/ack handshake, with a watchdog timeout.
module mdp_run_scheduler #(
    parameter int unsigned QDEPTH     = 4,
    parameter int unsigned START_HOLD = 2,
    parameter int unsigned TIMEOUT    = 4000
) (
    input  logic               clk,
    input  logic               Reset,
    mdp_run_scheduler_if.slave bus,
    output logic               busy,
    output logic [15:0]        run_count
);
    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned HW = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
    localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(QDEPTH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_ACK, S_RESP
    } state_t;

    typedef struct packed {
        logic [63:0] world;
        logic [7:0]  depth;
        logic [7:0]  width;
        logic [7:0]  iter;
        logic [7:0]  tag;
    } job_t;

    state_t        state, state_nxt;
    job_t          mem [QDEPTH];
    job_t          head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic [7:0]    tag_cnt;
    logic [HW-1:0] hold_cnt;
    logic [WW-1:0] wd_cnt;
    logic [15:0]   area;
    logic          push, pop, cfg_ok;

    // req_ready looks only at the stored count, so a pop never opens a slot in the same cycle
    assign bus.req_ready = (count < FULL_CNT);
    assign push          = bus.req_valid && bus.req_ready;
    assign head          = mem[rd_ptr];
    assign area          = 16'(head.depth) * 16'(head.width);
    assign cfg_ok        = (head.depth != '0) && (head.width != '0) && (area <= 16'd32);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = cfg_ok ? S_LOAD : S_RESP;
                end
            end
            S_LOAD:  state_nxt = S_START;
            S_START: if (hold_cnt == HOLD_LAST) state_nxt = S_WAIT;
            S_WAIT:  if (bus.eng_done || (wd_cnt == WD_LAST)) state_nxt = S_ACK;
            S_ACK:   if (bus.rsp_tmo || !bus.eng_done) state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE) || (count_nxt != '0);
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tag_cnt <= '0;
        end else begin
            count <= count_nxt;
            if (push) begin
                wr_ptr  <= wr_ptr + PW'(1);
                tag_cnt <= tag_cnt + 8'd1;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{world: bus.req_world, depth: bus.req_depth,
                                   width: bus.req_width, iter: bus.req_iter, tag: tag_cnt};
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            bus.eng_world  <= '0;
            bus.eng_depth  <= '0;
            bus.eng_width  <= '0;
            bus.eng_iter   <= '0;
            bus.eng_start  <= 1'b0;
            bus.eng_ack    <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_policy <= '0;
            bus.rsp_tag    <= '0;
            bus.rsp_err    <= 1'b0;
            bus.rsp_tmo    <= 1'b0;
            run_count      <= '0;
            hold_cnt       <= '0;
            wd_cnt         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        bus.eng_world <= head.world;
                        bus.eng_depth <= head.depth;
                        bus.eng_width <= head.width;
                        bus.eng_iter  <= head.iter;
                        bus.rsp_tag   <= head.tag;
                        if (!cfg_ok) begin
                            bus.rsp_err    <= 1'b1;
                            bus.rsp_policy <= '0;
                            bus.rsp_valid  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    bus.eng_start <= 1'b1;
                    hold_cnt      <= '0;
                end
                S_START: begin
                    if (hold_cnt == HOLD_LAST) begin
                        bus.eng_start <= 1'b0;
                        wd_cnt        <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                S_WAIT: begin
                    // done is checked first so it wins a tie with the watchdog
                    if (bus.eng_done) begin
                        bus.rsp_policy <= bus.eng_policy;
                        bus.eng_ack    <= 1'b1;
                    end else if (wd_cnt == WD_LAST) begin
                        bus.rsp_tmo    <= 1'b1;
                        bus.rsp_policy <= '0;
                        bus.eng_ack    <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WW'(1);
                    end
                end
                S_ACK: begin
                    if (bus.rsp_tmo || !bus.eng_done) begin
                        bus.eng_ack   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_tmo   <= 1'b0;
                        run_count     <= run_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
